// File: rtl/ft245_sched.sv
// ft245_sched
// Shares the FT245IO byte FIFO interface between four client channels.
// TX: one byte per grant, round-robin across the four requesters.
// RX: incoming bytes are parsed as {chan[1:0], len[5:0]} headers followed by
//     len payload bytes. Each payload byte is strobed to the addressed channel.
// Reads and writes alternate when both are possible.
//
// Ports
//   Clock           system clock, rising edge
//   Reset           synchronous, active-low
//   IoReadOK        FT245 RX FIFO has data
//   IoWriteOK       FT245 TX FIFO has space
//   IoReadReq       one-cycle read request pulse to FT245IO
//   IoWriteReq      one-cycle write request pulse to FT245IO
//   IoDataToSend    byte for FT245IO to write; held until the next write grant
//   IoReceivedData  byte last read by FT245IO
//   TxReq[3:0]      per-channel byte pending
//   TxData[31:0]    channel i byte on [8i+7:8i]
//   TxAck[3:0]      one-hot, one-cycle: channel byte taken
//   RxData[7:0]     routed payload byte
//   RxValid[3:0]    one-hot, one-cycle strobe qualifying RxData
//   FrameError      one-cycle pulse on a zero-length header
//   Busy            high while a request is settling
module ft245_sched #(
    parameter int unsigned SETTLE = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IoReadOK,
    input  logic        IoWriteOK,
    output logic        IoReadReq,
    output logic        IoWriteReq,
    output logic [7:0]  IoDataToSend,
    input  logic [7:0]  IoReceivedData,
    input  logic [3:0]  TxReq,
    input  logic [31:0] TxData,
    output logic [3:0]  TxAck,
    output logic [7:0]  RxData,
    output logic [3:0]  RxValid,
    output logic        FrameError,
    output logic        Busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RD, ST_WAIT_WR} state_t;
    typedef enum logic {PS_HDR, PS_PAYLOAD} pstate_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_rr_ptr;
    logic       r_last_rd;
    logic       r_rd_req, r_wr_req, r_busy, r_ferr;
    logic [7:0] r_tx_byte, r_rx_data;
    logic [3:0] r_tx_ack, r_rx_valid;

    pstate_t    r_ps, w_ps_nxt;
    logic [5:0] r_remain, w_remain_nxt;
    logic [1:0] r_chan, w_chan_nxt;
    logic [7:0] w_rx_data_nxt;
    logic [3:0] w_rx_valid_nxt;
    logic       w_ferr_nxt;

    logic       w_decide, w_rd_elig, w_wr_elig, w_grant_rd, w_grant_wr, w_sample;
    logic [1:0] w_ch, w_idx;
    logic       w_found;

    // The last settle cycle doubles as the IDLE decision slot, so a request
    // granted there pulses SETTLE+1 cycles after the previous one.
    assign w_decide   = (r_state == ST_IDLE) || (r_cnt == 4'(SETTLE));
    assign w_rd_elig  = IoReadOK;
    assign w_wr_elig  = IoWriteOK && (TxReq != 4'b0000);
    assign w_grant_rd = w_decide && w_rd_elig && (!w_wr_elig || !r_last_rd);
    assign w_grant_wr = w_decide && w_wr_elig && !w_grant_rd;
    assign w_sample   = (r_state == ST_WAIT_RD) && (r_cnt == 4'(SETTLE));

    // First requesting channel after the last one served, wrapping.
    always_comb begin
        w_ch    = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_rr_ptr + k[1:0];
            if (!w_found && TxReq[w_idx]) begin
                w_ch    = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_grant_rd) begin
            w_state_nxt = ST_WAIT_RD;
            w_cnt_nxt   = '0;
        end else if (w_grant_wr) begin
            w_state_nxt = ST_WAIT_WR;
            w_cnt_nxt   = '0;
        end else if (w_decide) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_ps_nxt       = r_ps;
        w_remain_nxt   = r_remain;
        w_chan_nxt     = r_chan;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = '0;
        w_ferr_nxt     = 1'b0;
        if (w_sample) begin
            if (r_ps == PS_HDR) begin
                if (IoReceivedData[5:0] == 6'd0) begin
                    w_ferr_nxt = 1'b1;
                end else begin
                    w_chan_nxt   = IoReceivedData[7:6];
                    w_remain_nxt = IoReceivedData[5:0];
                    w_ps_nxt     = PS_PAYLOAD;
                end
            end else begin
                w_rx_data_nxt  = IoReceivedData;
                w_rx_valid_nxt = 4'b0001 << r_chan;
                w_remain_nxt   = r_remain - 6'd1;
                if (r_remain == 6'd1) w_ps_nxt = PS_HDR;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= 2'd3;
            r_last_rd  <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_tx_byte  <= '0;
            r_tx_ack   <= '0;
            r_busy     <= 1'b0;
            r_ps       <= PS_HDR;
            r_remain   <= '0;
            r_chan     <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_req   <= w_grant_rd;
            r_wr_req   <= w_grant_wr;
            r_tx_ack   <= w_grant_wr ? (4'b0001 << w_ch) : 4'b0000;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_grant_wr) begin
                r_tx_byte <= TxData[{w_ch, 3'b000} +: 8];
                r_rr_ptr  <= w_ch;
            end
            if (w_grant_rd || w_grant_wr) r_last_rd <= w_grant_rd;
            r_ps       <= w_ps_nxt;
            r_remain   <= w_remain_nxt;
            r_chan     <= w_chan_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    assign IoReadReq    = r_rd_req;
    assign IoWriteReq   = r_wr_req;
    assign IoDataToSend = r_tx_byte;
    assign TxAck        = r_tx_ack;
    assign Busy         = r_busy;
    assign RxData       = r_rx_data;
    assign RxValid      = r_rx_valid;
    assign FrameError   = r_ferr;

endmodule

// File: tb/tb_ft245_sched.sv
// Directed bench for ft245_sched (SETTLE=3): single write, round robin,
// read/write alternation, framed RX, zero-length header, reset mid-frame.
module tb_ft245_sched;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IoReadOK, IoWriteOK;
    logic        IoReadReq, IoWriteReq;
    logic [7:0]  IoDataToSend, IoReceivedData;
    logic [3:0]  TxReq, TxAck;
    logic [31:0] TxData;
    logic [7:0]  RxData;
    logic [3:0]  RxValid;
    logic        FrameError, Busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [3:0] got_v[$];
    logic [7:0] got_d[$];
    int         fe_cnt;
    int         fe_with_valid;

    always #5 Clock = ~Clock;

    ft245_sched #(.SETTLE(3)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .IoReadOK       (IoReadOK),
        .IoWriteOK      (IoWriteOK),
        .IoReadReq      (IoReadReq),
        .IoWriteReq     (IoWriteReq),
        .IoDataToSend   (IoDataToSend),
        .IoReceivedData (IoReceivedData),
        .TxReq          (TxReq),
        .TxData         (TxData),
        .TxAck          (TxAck),
        .RxData         (RxData),
        .RxValid        (RxValid),
        .FrameError     (FrameError),
        .Busy           (Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Leaves the bench in the first cycle with Reset released.
    task automatic do_reset();
        Reset = 1'b0;
        IoReceivedData = 8'h00;
        cyc();
        cyc();
        Reset = 1'b1;
    endtask

    // Cycles until a request pulse is seen; dt = cycles waited, -1 on timeout.
    task automatic wait_pulse(output int dt);
        dt = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (IoReadReq || IoWriteReq) begin
                dt = i;
                break;
            end
        end
    endtask

    // Serves n_reads bytes from rx_q and records every RX strobe.
    task automatic run_rx(input int n_reads);
        int reads = 0;
        int after = 0;
        got_v.delete();
        got_d.delete();
        fe_cnt = 0;
        fe_with_valid = 0;
        IoWriteOK = 1'b0;
        TxReq = 4'b0000;
        IoReadOK = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (IoReadReq) begin
                if (rx_q.size() > 0) IoReceivedData = rx_q.pop_front();
                else IoReceivedData = 8'h00;
                reads++;
                if (reads == n_reads) IoReadOK = 1'b0;
            end
            if (RxValid != 4'b0000) begin
                got_v.push_back(RxValid);
                got_d.push_back(RxData);
            end
            if (FrameError) begin
                fe_cnt++;
                if (RxValid != 4'b0000) fe_with_valid++;
            end
            if (reads >= n_reads) begin
                after++;
                if (after > 8) break;
            end
        end
        chk("rx_reads", reads, n_reads);
    endtask

    initial begin
        int dt;
        int extra;
        int exp_ack[5];
        int exp_dat[5];

        Reset = 1'b0;
        IoReadOK = 1'b0;
        IoWriteOK = 1'b0;
        IoReceivedData = 8'h00;
        TxReq = 4'b0000;
        TxData = 32'h0;

        // Single write on channel 2
        IoWriteOK = 1'b1;
        TxData = 32'h00A5_0000;
        TxReq = 4'b0100;
        do_reset();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_wrreq", 32'(IoWriteReq), 0);
        chk("rst_txack", 32'(TxAck), 0);
        chk("rst_data", 32'(IoDataToSend), 0);
        cyc();
        chk("wr_pulse", 32'(IoWriteReq), 1);
        chk("wr_ack", 32'(TxAck), 32'h4);
        chk("wr_data", 32'(IoDataToSend), 32'hA5);
        chk("wr_busy0", 32'(Busy), 1);
        TxReq = 4'b0000;
        TxData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wr_busy", 32'(Busy), 1);
            chk("wr_ack_drop", 32'(TxAck), 0);
        end
        cyc();
        chk("wr_idle", 32'(Busy), 0);
        chk("wr_hold", 32'(IoDataToSend), 32'hA5);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (IoWriteReq || IoReadReq) extra++;
        end
        chk("wr_no_extra", extra, 0);

        // Round robin, all channels requesting
        exp_ack = '{1, 2, 4, 8, 1};
        exp_dat = '{32'hA0, 32'hB1, 32'hC2, 32'hD3, 32'hA0};
        IoReadOK = 1'b0;
        IoWriteOK = 1'b1;
        TxData = 32'hD3C2_B1A0;
        TxReq = 4'b1111;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            wait_pulse(dt);
            chk("rr_spacing", dt, (p == 0) ? 1 : 4);
            chk("rr_ack", 32'(TxAck), exp_ack[p]);
            chk("rr_data", 32'(IoDataToSend), exp_dat[p]);
            chk("rr_no_rd", 32'(IoReadReq), 0);
        end

        // Read/write alternation, read first after reset
        IoReadOK = 1'b1;
        IoWriteOK = 1'b1;
        TxData = 32'h0000_00EE;
        TxReq = 4'b0001;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            wait_pulse(dt);
            chk("alt_spacing", dt, (p == 0) ? 1 : 4);
            chk("alt_rd", 32'(IoReadReq), ((p % 2) == 0) ? 1 : 0);
            chk("alt_wr", 32'(IoWriteReq), ((p % 2) == 1) ? 1 : 0);
        end
        IoReadOK = 1'b0;
        IoWriteOK = 1'b0;
        TxReq = 4'b0000;

        // Framed RX: ch2 len3, then ch0 len1
        rx_q = '{8'h83, 8'h11, 8'h22, 8'h33, 8'h01, 8'h44};
        do_reset();
        run_rx(6);
        chk("frm_count", got_v.size(), 4);
        chk("frm_ferr", fe_cnt, 0);
        if (got_v.size() == 4) begin
            chk("frm_v0", 32'(got_v[0]), 32'h4);
            chk("frm_d0", 32'(got_d[0]), 32'h11);
            chk("frm_v1", 32'(got_v[1]), 32'h4);
            chk("frm_d1", 32'(got_d[1]), 32'h22);
            chk("frm_v2", 32'(got_v[2]), 32'h4);
            chk("frm_d2", 32'(got_d[2]), 32'h33);
            chk("frm_v3", 32'(got_v[3]), 32'h1);
            chk("frm_d3", 32'(got_d[3]), 32'h44);
        end

        // Zero-length header, then ch1 len2 with one payload byte
        rx_q = '{8'hC0, 8'h42, 8'h99};
        do_reset();
        run_rx(3);
        chk("fe_count", fe_cnt, 1);
        chk("fe_no_valid", fe_with_valid, 0);
        chk("fe_strobes", got_v.size(), 1);
        if (got_v.size() == 1) begin
            chk("fe_v", 32'(got_v[0]), 32'h2);
            chk("fe_d", 32'(got_d[0]), 32'h99);
        end

        // Reset mid-frame: ch0 len5, two payload bytes, then reset
        rx_q = '{8'h05, 8'h11, 8'h22};
        do_reset();
        run_rx(3);
        chk("mid_strobes", got_v.size(), 2);
        if (got_v.size() == 2) begin
            chk("mid_v", 32'(got_v[1]), 32'h1);
            chk("mid_d", 32'(got_d[1]), 32'h22);
        end
        Reset = 1'b0;
        cyc();
        chk("mid_busy", 32'(Busy), 0);
        chk("mid_rdreq", 32'(IoReadReq), 0);
        chk("mid_wrreq", 32'(IoWriteReq), 0);
        chk("mid_txdata", 32'(IoDataToSend), 0);
        chk("mid_txack", 32'(TxAck), 0);
        chk("mid_rxdata", 32'(RxData), 0);
        chk("mid_rxvalid", 32'(RxValid), 0);
        chk("mid_ferr", 32'(FrameError), 0);
        Reset = 1'b1;
        rx_q = '{8'h41, 8'h77};
        run_rx(2);
        chk("post_strobes", got_v.size(), 1);
        chk("post_ferr", fe_cnt, 0);
        if (got_v.size() == 1) begin
            chk("post_v", 32'(got_v[0]), 32'h2);
            chk("post_d", 32'(got_d[0]), 32'h77);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft245_sched.md
# ft245_sched

Controller that sequences and shares the FT245 byte-wide USB FIFO interface (FT245IO) between four on-chip client channels. The transmit side round-robins one byte at a time among four requesters. The receive side parses incoming bytes into framed packets and routes each payload byte to the addressed channel. The block sits directly above FT245IO: it drives FT245IO's ReadReq/WriteReq/DataToSend and consumes its ReceivedData.

## Interface
- SETTLE, 3: wait cycles after each FT245IO request pulse before the next decision or data sample; legal range 3..15.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- IoReadOK  in  1  FT245 RX FIFO has data; same signal FT245IO sees.
- IoWriteOK  in  1  FT245 TX FIFO has space.
- IoReadReq  out  1  one-cycle read request pulse to FT245IO.
- IoWriteReq  out  1  one-cycle write request pulse to FT245IO.
- IoDataToSend  out  8  byte for FT245IO to write.
- IoReceivedData  in  8  byte last read by FT245IO.
- TxReq  in  4  per-channel "byte pending"; bit i is channel i.
- TxData  in  32  channel i byte on bits [8i+7:8i]; must be stable while TxReq[i] is high.
- TxAck  out  4  one-hot, one-cycle: channel's byte taken; the client may change TxData or drop TxReq next cycle.
- RxData  out  8  routed payload byte.
- RxValid  out  4  one-hot, one-cycle strobe qualifying RxData for channel i.
- FrameError  out  1  one-cycle pulse when a header with length 0 is received.
- Busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT_RD, WAIT_WR.
- Eligibility in IDLE:
  - Read is eligible when IoReadOK=1.
  - Write is eligible when IoWriteOK=1 and TxReq≠0.
- Arbitration in IDLE:
  - If both are eligible, pick the opposite of the last executed op (flag LastRd).
  - Otherwise pick whichever is eligible.
  - If neither is eligible, stay in IDLE.
- Read grant:
  - Pulse IoReadReq and go to WAIT_RD.
- Write grant:
  - Channel = first set TxReq bit searching from (RrPtr+1) mod 4 upward, wrapping.
  - Latch that channel's TxData into IoDataToSend.
  - Pulse IoWriteReq and TxAck[ch] together.
  - Set RrPtr=ch and go to WAIT_WR.
- WAIT states: count SETTLE cycles, then return to IDLE.
  - On leaving WAIT_RD, sample IoReceivedData into the RX parser.
- IoDataToSend holds the latched byte from the pulse cycle until the next write grant.
- RX parser states: HDR and PAYLOAD.
- In HDR, the byte is a header: bits[7:6] = channel C, bits[5:0] = length L.
  - L=0: pulse FrameError, stay in HDR, deliver nothing.
  - Else: store C, Remaining=L, go to PAYLOAD.
- In PAYLOAD, each byte is a payload byte:
  - RxData=byte, RxValid[C]=1 for one cycle.
  - Remaining decrements; on reaching 0 the parser returns to HDR.
- Remaining is 6 bits; no wrap is possible since L≤63.
- Clients cannot stall RX and must accept every RxValid strobe.
- Reset values:
  - State=IDLE, parser=HDR, Remaining=0, C=0, RrPtr=3 (channel 0 is served first), LastRd=0 (a read wins the first tie).
  - IoReadReq=0, IoWriteReq=0, IoDataToSend=0, TxAck=0, RxData=0, RxValid=0, FrameError=0, Busy=0.

## Timing
- Request timing:
  - A decision in IDLE during cycle n-1 makes the request pulse and TxAck high in cycle n.
  - WAIT occupies cycles n..n+SETTLE.
  - IDLE is back in cycle n+SETTLE+1.
  - The minimum pulse-to-pulse spacing is SETTLE+1 cycles.
- Read data:
  - IoReceivedData is sampled at the rising edge that ends cycle n+SETTLE.
  - RxValid or FrameError is high in cycle n+SETTLE+1.
  - This matches FT245IO's 2-cycle read capture with 1 cycle of margin when SETTLE=3.
- Busy is registered and high in cycles n..n+SETTLE.
- IoReadOK and IoWriteOK are sampled only in IDLE. Changes during WAIT are ignored.
- TxReq dropping before grant is legal. The request is simply not served.
- Reset low on any edge has these effects:
  - All state returns to reset values on the next edge, including mid-WAIT and mid-frame.
  - A partial RX frame is discarded.
  - No pulse is issued in the cycle after reset is released.

## Test plan
- Single write: SETTLE=3, IoWriteOK=1, IoReadOK=0, TxReq=4'b0100, TxData[23:16]=8'hA5 → IoWriteReq and TxAck=4'b0100 in the same cycle, IoDataToSend=8'hA5, Busy for 4 cycles, no further pulse while TxReq stays low.
- Round robin: TxReq=4'b1111 held, IoWriteOK=1 → channel grant order 0,1,2,3,0, write pulses exactly 4 cycles apart.
- Read/write alternation: IoReadOK=1, IoWriteOK=1, TxReq=4'b0001 held → pulse sequence Rd,Wr,Rd,Wr starting with Rd after reset.
- Framed RX: read bytes 8'h83, 8'h11, 8'h22, 8'h33 then 8'h01, 8'h44 → RxValid=4'b0100 with RxData 11,22,33; then RxValid=4'b0001 with RxData 44.
- Framing error: header 8'hC0 → FrameError pulse, no RxValid. The next byte 8'h42, 8'h99 delivers 8'h99 on RxValid=4'b0010.
- Reset mid-frame: after header 8'h05 and 2 payload bytes, pulse Reset=0 for one cycle → Busy=0 and all outputs 0. The next read byte 8'h41 is treated as a header (channel 1, length 1), not as payload.
